// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with CTRL/PRESET/COUNT registers,
// one-shot or auto-reload operation and a maskable interrupt request.
module timer_counter #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    // Byte-lane merge: each enabled lane takes the new byte, others keep the old one.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        irq_q;

    logic        hit_s;
    logic [1:0]  sel_s;
    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        en_clr_s;
    logic        unused_addr_bits;

    // Word offset within the window is all that matters; byte offset is ignored.
    assign unused_addr_bits = ^addr[1:0];
    assign sel_s            = addr[3:2];

    // Address decode and write strobes; the slot at offset 12 is a hole.
    always_comb begin
        hit_s       = 1'b0;
        wr_ctrl_s   = 1'b0;
        wr_preset_s = 1'b0;
        if ((addr[31:4] == BASE[31:4]) && (sel_s != 2'b11)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (hit_s && (byteen != 4'b0000)) begin
            wr_ctrl_s   = (sel_s == SEL_CTRL);
            wr_preset_s = (sel_s == SEL_PRESET);
        end else begin
            wr_ctrl_s   = 1'b0;
            wr_preset_s = 1'b0;
        end
    end

    // Combinational read mux; misses return zero.
    always_comb begin
        rdata = 32'h0000_0000;
        if (hit_s) begin
            case (sel_s)
                SEL_CTRL:   rdata = {28'h000_0000, ctrl_q};
                SEL_PRESET: rdata = preset_q;
                SEL_COUNT:  rdata = count_q;
                default:    rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // Counter FSM next state; decisions use the current (pre-edge) CTRL and PRESET.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        en_clr_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = S_INT;
                end
            end
            S_INT: begin
                if (ctrl_q[2:1] == MODE_RELOAD) begin
                    irq_flag_d = 1'b0;
                    state_d    = S_LOAD;
                end else begin
                    en_clr_s = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A CPU write to CTRL always acknowledges a pending interrupt.
        if (wr_ctrl_s) begin
            irq_flag_d = 1'b0;
        end else begin
            irq_flag_d = irq_flag_d;
        end
    end

    // Register-file next values; a CPU write to CTRL wins over the FSM's EN clear.
    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        if (en_clr_s) begin
            ctrl_d[0] = 1'b0;
        end else begin
            ctrl_d[0] = ctrl_q[0];
        end
        if (wr_ctrl_s && byteen[0]) begin
            ctrl_d = wdata[3:0];
        end else begin
            ctrl_d = ctrl_d;
        end
        if (wr_preset_s) begin
            preset_d = merge_lanes(preset_q, wdata, byteen);
        end else begin
            preset_d = preset_q;
        end
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'h0;
            preset_q   <= 32'h0000_0000;
            count_q    <= 32'h0000_0000;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= ctrl_d[3] & irq_flag_d;
        end
    end

    assign irq = irq_q;

endmodule
